// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: shares one multicycle start/done multiply unit among N
// requesters. Operands are latched per requester, grants are round-robin, and
// a watchdog forces completion (result 0) if the multiplier never answers.
//
// state | meaning
// IDLE  | pick the next pending requester after the last grant, launch it
// ISSUE | mul_start high for this single cycle, watchdog armed
// WAIT  | waiting for mul_done or watchdog expiry
// RESP  | req_done[g] and req_result presented, pending[g] released
module mult_share_arbiter #(
    parameter int N       = 4,
    parameter int TIMEOUT = 80
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clk_en,
    input  logic [N-1:0]    req_start,
    input  logic [32*N-1:0] req_dataa,
    input  logic [32*N-1:0] req_datab,
    output logic [N-1:0]    req_done,
    output logic [31:0]     req_result,
    output logic            mul_start,
    output logic [31:0]     mul_dataa,
    output logic [31:0]     mul_datab,
    input  logic            mul_done,
    input  logic [31:0]     mul_result,
    output logic            busy,
    output logic            err_overrun,
    output logic            err_timeout
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]    r_state;
    logic [N-1:0]  r_pending;
    logic [31:0]   r_opa [N];
    logic [31:0]   r_opb [N];
    logic [IW-1:0] r_last;
    logic [IW-1:0] r_grant;
    logic [WW-1:0] r_wd;

    logic [N-1:0]  w_clr;
    logic [N-1:0]  w_pend_eff;
    logic [N-1:0]  w_accept;
    logic          w_overrun;
    logic [N-1:0]  w_grant_oh;
    logic          w_found;
    logic [IW-1:0] w_gidx;
    logic [IW-1:0] w_cand;

    // Release of the responding requester and start acceptance; a start in the
    // release cycle is accepted rather than flagged as an overrun.
    always_comb begin
        w_clr = '0;
        if (r_state == S_RESP) begin
            w_clr[r_grant] = 1'b1;
        end
        w_pend_eff = r_pending & ~w_clr;
        w_accept   = req_start & ~w_pend_eff;
        w_overrun  = |(req_start & w_pend_eff);
        w_grant_oh = '0;
        w_grant_oh[r_grant] = 1'b1;
    end

    // Round-robin search: first pending index strictly after the last grant.
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        w_cand  = '0;
        for (int k = 1; k <= N; k++) begin
            w_cand = IW'((int'(r_last) + k) % N);
            if (!w_found && r_pending[w_cand]) begin
                w_found = 1'b1;
                w_gidx  = w_cand;
            end
        end
    end

    // Pending flags: set on accepted start, cleared while the response is out.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= '0;
        end else if (clk_en) begin
            r_pending <= w_pend_eff | w_accept;
        end
    end

    // Operand latches; contents are only meaningful while pending is set.
    always_ff @(posedge clk) begin
        if (clk_en) begin
            for (int i = 0; i < N; i++) begin
                if (w_accept[i]) begin
                    r_opa[i] <= req_dataa[32*i +: 32];
                    r_opb[i] <= req_datab[32*i +: 32];
                end
            end
        end
    end

    // Sequencer with registered outputs; watchdog is a down-counter that
    // expires on reaching zero, giving TIMEOUT cycles in WAIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_last      <= IW'(N - 1);
            r_grant     <= '0;
            r_wd        <= '0;
            mul_start   <= 1'b0;
            mul_dataa   <= '0;
            mul_datab   <= '0;
            req_done    <= '0;
            req_result  <= '0;
            err_overrun <= 1'b0;
            err_timeout <= 1'b0;
        end else if (clk_en) begin
            mul_start   <= 1'b0;
            req_done    <= '0;
            err_timeout <= 1'b0;
            err_overrun <= w_overrun;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_last    <= w_gidx;
                        r_grant   <= w_gidx;
                        mul_dataa <= r_opa[w_gidx];
                        mul_datab <= r_opb[w_gidx];
                        mul_start <= 1'b1;
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_wd    <= WW'(TIMEOUT - 1);
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (mul_done) begin
                        req_result <= mul_result;
                        req_done   <= w_grant_oh;
                        r_state    <= S_RESP;
                    end else if (r_wd == '0) begin
                        req_result  <= '0;
                        req_done    <= w_grant_oh;
                        err_timeout <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_wd <= r_wd - 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = (r_state != S_IDLE) || (|r_pending);

endmodule
